// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared OpenMIPS fetch constants
package pc_fetch_ctrl_pkg;
   localparam int unsigned ADDR_W       = 32;
   localparam int unsigned INST_W       = 32;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0000;
   localparam int unsigned PC_STEP      = 4;
endpackage

// File: rtl/pc_fetch_ctrl_fetch_fifo.sv
// rtl/pc_fetch_ctrl_fetch_fifo.sv - synchronous fetch FIFO with single-cycle flush
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head_data,
   output logic             not_empty,
   output logic             full
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage needs no reset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];
   assign not_empty = (count != '0);
   assign full      = (count == CNT_W'(DEPTH));
endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - OpenMIPS instruction-fetch front end (PC, ROM access, fetch FIFO)
module pc_fetch_ctrl #(
   parameter int unsigned              ADDR_W   = pc_fetch_ctrl_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0]        RESET_PC = ADDR_W'(pc_fetch_ctrl_pkg::RESET_VECTOR),
   parameter int unsigned              DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_inst,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [ADDR_W-1:0] id_pc,
   output logic [31:0]       id_inst,
   output logic              misalign_err
);
   import pc_fetch_ctrl_pkg::*;

   localparam int unsigned ENTRY_W = ADDR_W + INST_W;

   logic [ADDR_W-1:0]  pc;
   logic               ce_armed;
   logic               fifo_valid;
   logic               fifo_full;
   logic               fire;
   logic               pop;
   logic [ENTRY_W-1:0] head;

   // ROM stays disabled during reset and for one cycle after it is released.
   assign rom_ce   = ce_armed & ~rst;
   assign rom_addr = pc;

   assign pop  = fifo_valid & id_ready & ~redirect_valid;
   assign fire = rom_ce & ~stall & ~redirect_valid & (~fifo_full | pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         ce_armed     <= 1'b0;
         pc           <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         ce_armed <= 1'b1;
         if (redirect_valid) begin
            pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
         end else if (fire) begin
            pc <= pc + ADDR_W'(PC_STEP);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fetch_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (fire),
      .pop       (pop),
      .push_data ({pc, rom_inst}),
      .head_data (head),
      .not_empty (fifo_valid),
      .full      (fifo_full)
   );

   // A redirect hides the head immediately; it is flushed at the same edge.
   assign id_valid = fifo_valid & ~redirect_valid;
   assign id_pc    = fifo_valid ? head[ENTRY_W-1 -: ADDR_W] : '0;
   assign id_inst  = fifo_valid ? head[INST_W-1:0] : NOP_INST;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        misalign_err;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] exp_q [$];
   logic [63:0] exp_e;

   pc_fetch_ctrl #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .rom_ce         (rom_ce),
      .rom_addr       (rom_addr),
      .rom_inst       (rom_inst),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_inst        (id_inst),
      .misalign_err   (misalign_err)
   );

   // ROM word i holds i+1
   assign rom_inst = (rom_addr >> 2) + 32'd1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic expect_out(input logic [31:0] pc, input logic [31:0] inst);
      exp_q.push_back({pc, inst});
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         step();
         n++;
      end
      chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clk);
      chk({name, "_no_extra"}, 64'(id_valid), 64'd0);
   endtask

   // Monitor: every accepted head must match the next expected entry.
   always @(negedge clk) begin
      if (!rst && id_valid && id_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got pc=%h inst=%h, required no output", id_pc, id_inst);
         end else begin
            exp_e = exp_q.pop_front();
            chk("stream", {id_pc, id_inst}, exp_e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; id_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_rom_ce",   64'(rom_ce), 64'd0);
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_id_pc",    64'(id_pc), 64'd0);
      chk("rst_id_inst",  64'(id_inst), 64'd0);
      chk("rst_misalign", 64'(misalign_err), 64'd0);
      chk("rst_rom_addr", 64'(rom_addr), 64'd0);

      // 1: reset release, full-rate stream of three instructions
      step();
      rst = 1'b0;
      expect_out(32'h0, 32'h1);
      expect_out(32'h4, 32'h2);
      expect_out(32'h8, 32'h3);
      @(negedge clk);
      chk("t1_ce_first_cycle", 64'(rom_ce), 64'd0);
      step();
      @(negedge clk);
      chk("t1_ce_second_cycle", 64'(rom_ce), 64'd1);
      chk("t1_not_yet_valid",   64'(id_valid), 64'd0);
      step();
      @(negedge clk);
      chk("t1_valid_c", 64'(id_valid), 64'd1);
      step();
      @(negedge clk);
      chk("t1_valid_d", 64'(id_valid), 64'd1);
      step();
      stall = 1'b1;
      @(negedge clk);
      chk("t1_valid_e", 64'(id_valid), 64'd1);
      wait_drain("t1");

      // 2: backpressure fills the FIFO, PC holds at 8
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      step();
      redirect_valid = 1'b0; id_ready = 1'b0; stall = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c >= 2) chk("t2_hold_head", {id_pc, id_inst}, {32'h0, 32'h1});
         if (c >= 3) chk("t2_rom_addr", 64'(rom_addr), 64'h8);
         step();
      end
      expect_out(32'h0, 32'h1);
      expect_out(32'h4, 32'h2);
      expect_out(32'h8, 32'h3);
      id_ready = 1'b1;
      step();
      stall = 1'b1;
      wait_drain("t2");

      // 3: redirect while full to 0x100
      step();
      id_ready = 1'b0; stall = 1'b0;
      step();
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h100; id_ready = 1'b1;
      expect_out(32'h100, 32'h41);
      expect_out(32'h104, 32'h42);
      @(negedge clk);
      chk("t3_valid_in_redirect", 64'(id_valid), 64'd0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t3_valid_after_redirect", 64'(id_valid), 64'd0);
      step();
      step();
      stall = 1'b1;
      wait_drain("t3");

      // 4: redirect together with stall, misaligned target
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h203; stall = 1'b1;
      @(negedge clk);
      chk("t4_misalign_before", 64'(misalign_err), 64'd0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t4_pc_aligned", 64'(rom_addr), 64'h200);
      chk("t4_misalign_set", 64'(misalign_err), 64'd1);
      step();
      expect_out(32'h200, 32'h81);
      stall = 1'b0;
      step();
      stall = 1'b1;
      wait_drain("t4");
      chk("t4_misalign_sticky", 64'(misalign_err), 64'd1);

      // 5: PC wraps from FFFF_FFFC to 0
      step();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; stall = 1'b0;
      expect_out(32'hFFFF_FFFC, 32'h4000_0000);
      expect_out(32'h0, 32'h1);
      step();
      redirect_valid = 1'b0;
      step();
      step();
      stall = 1'b1;
      @(negedge clk);
      chk("t5_rom_addr_wrapped", 64'(rom_addr), 64'h4);
      wait_drain("t5");
      chk("t5_misalign_sticky", 64'(misalign_err), 64'd1);

      // 6: reset pulse with a non-empty FIFO
      step();
      id_ready = 1'b0; stall = 1'b0;
      step();
      step();
      rst = 1'b1; stall = 1'b1;
      @(negedge clk);
      chk("t6_ce_in_rst", 64'(rom_ce), 64'd0);
      step();
      rst = 1'b0; id_ready = 1'b1; stall = 1'b0;
      expect_out(32'h0, 32'h1);
      expect_out(32'h4, 32'h2);
      @(negedge clk);
      chk("t6_valid_after_rst", 64'(id_valid), 64'd0);
      chk("t6_rom_addr",        64'(rom_addr), 64'h0);
      chk("t6_misalign_clear",  64'(misalign_err), 64'd0);
      chk("t6_ce_after_rst",    64'(rom_ce), 64'd0);
      step();
      step();
      step();
      stall = 1'b1;
      wait_drain("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
